// File: rtl/execute.sv
// Execute stage of the RV32I five-stage pipeline.
// Registers the decoded instruction, runs the ALU, resolves branches and
// jumps, and redirects fetch with a one-cycle execute_change_pc pulse.
//
// One-hot encodings shared with decode:
//   decode_alu_type    : 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND,
//                        7 SLL, 8 SRL, 9 SRA, 10 EQ, 11 NEQ, 12 GE, 13 GEU
//                        (BLT/BLTU are issued as SLT/SLTU)
//   decode_opcode_type : 0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL,
//                        6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE
//   exception bits     : 0 instruction-address-misaligned (raised here),
//                        upper bits are passed through from upstream.
//
// Handshake: an instruction moves from decode into this stage on a rising
// edge when clk_en=1, stall=0, flush=0 and no redirect pulse is in flight.
// stall freezes every register except the redirect pulse; flush beats stall.
module execute #(
  parameter int XLEN            = 32,
  parameter int ALU_WIDTH       = 14,
  parameter int OPCODE_WIDTH    = 11,
  parameter int EXCEPTION_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                decode_pc,
  input  logic [4:0]                 decode_r_rs1,
  input  logic [4:0]                 decode_r_rs2,
  input  logic [4:0]                 decode_r_rd,
  input  logic [31:0]                rs1_data,
  input  logic [31:0]                rs2_data,
  input  logic [31:0]                decode_imm,
  input  logic [2:0]                 decode_funct3,
  input  logic [ALU_WIDTH-1:0]       decode_alu_type,
  input  logic [OPCODE_WIDTH-1:0]    decode_opcode_type,
  input  logic [EXCEPTION_WIDTH-1:0] decode_exception,
  output logic [31:0]                execute_result,
  output logic [31:0]                execute_rs2_data,
  output logic [4:0]                 execute_r_rd,
  output logic [2:0]                 execute_funct3,
  output logic [31:0]                execute_pc,
  output logic [OPCODE_WIDTH-1:0]    execute_opcode_type,
  output logic [EXCEPTION_WIDTH-1:0] execute_exception,
  output logic                       execute_change_pc,
  output logic [31:0]                execute_next_pc,
  input  logic                       clk_en,
  output logic                       next_clk_en,
  input  logic                       stall,
  output logic                       next_stall,
  input  logic                       flush,
  output logic                       next_flush
);

  localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4;
  localparam int A_OR = 5, A_AND = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9;
  localparam int A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;

  localparam int O_RTYPE = 0, O_BRANCH = 4, O_JAL = 5, O_JALR = 6;
  localparam int O_LUI = 7, O_AUIPC = 8;

  localparam int E_MISALIGNED = 0;

  // Register addresses are only needed by the hazard unit upstream.
  logic unused_addr;
  assign unused_addr = ^{decode_r_rs1, decode_r_rs2};

  logic        is_rtype, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic [31:0] op_a, op_b, alu_out;
  logic [4:0]  shamt;
  logic [31:0] pc_plus_imm, jalr_target, target, link, result;
  logic        take, misaligned, redirect, accept;
  logic [EXCEPTION_WIDTH-1:0] exception_in;

  assign is_rtype  = decode_opcode_type[O_RTYPE];
  assign is_branch = decode_opcode_type[O_BRANCH];
  assign is_jal    = decode_opcode_type[O_JAL];
  assign is_jalr   = decode_opcode_type[O_JALR];
  assign is_lui    = decode_opcode_type[O_LUI];
  assign is_auipc  = decode_opcode_type[O_AUIPC];

  // Operand selection: PC-relative ops use the PC, LUI adds to zero.
  always_comb begin
    op_a = rs1_data;
    if (is_auipc || is_jal || is_jalr) op_a = decode_pc;
    else if (is_lui)                   op_a = 32'd0;
    op_b = (is_rtype || is_branch) ? rs2_data : decode_imm;
  end

  assign shamt = op_b[4:0];

  // One-hot ALU; an illegal (zero or multi-hot) selector yields 0.
  always_comb begin
    alu_out = 32'd0;
    case (decode_alu_type)
      ALU_WIDTH'(1) << A_ADD:  alu_out = op_a + op_b;
      ALU_WIDTH'(1) << A_SUB:  alu_out = op_a - op_b;
      ALU_WIDTH'(1) << A_SLT:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_WIDTH'(1) << A_SLTU: alu_out = {31'd0, op_a < op_b};
      ALU_WIDTH'(1) << A_XOR:  alu_out = op_a ^ op_b;
      ALU_WIDTH'(1) << A_OR:   alu_out = op_a | op_b;
      ALU_WIDTH'(1) << A_AND:  alu_out = op_a & op_b;
      ALU_WIDTH'(1) << A_SLL:  alu_out = op_a << shamt;
      ALU_WIDTH'(1) << A_SRL:  alu_out = op_a >> shamt;
      ALU_WIDTH'(1) << A_SRA:  alu_out = $unsigned($signed(op_a) >>> shamt);
      ALU_WIDTH'(1) << A_EQ:   alu_out = {31'd0, op_a == op_b};
      ALU_WIDTH'(1) << A_NEQ:  alu_out = {31'd0, op_a != op_b};
      ALU_WIDTH'(1) << A_GE:   alu_out = {31'd0, $signed(op_a) >= $signed(op_b)};
      ALU_WIDTH'(1) << A_GEU:  alu_out = {31'd0, op_a >= op_b};
      default:                 alu_out = 32'd0;
    endcase
  end

  // Control-flow resolution: a misaligned target raises an exception instead
  // of redirecting fetch.
  always_comb begin
    pc_plus_imm = decode_pc + decode_imm;
    jalr_target = (rs1_data + decode_imm) & ~32'd1;
    target      = is_jalr ? jalr_target : pc_plus_imm;
    link        = decode_pc + 32'd4;
    result      = (is_jal || is_jalr) ? link : alu_out;
    take        = is_jal || is_jalr || (is_branch && alu_out[0]);
    misaligned  = take && (target[1:0] != 2'b00);
    redirect    = take && !misaligned;
    exception_in = decode_exception;
    if (misaligned) exception_in[E_MISALIGNED] = 1'b1;
  end

  // The instruction right behind a redirect is dropped.
  assign accept = clk_en && !stall && !flush && !execute_change_pc;

  assign next_stall = stall;
  assign next_flush = flush || execute_change_pc;

  // Pipeline register: flush clears, stall holds, accept loads, else bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      execute_result      <= '0;
      execute_rs2_data    <= '0;
      execute_r_rd        <= '0;
      execute_funct3      <= '0;
      execute_pc          <= '0;
      execute_opcode_type <= '0;
      execute_exception   <= '0;
      execute_change_pc   <= 1'b0;
      execute_next_pc     <= '0;
      next_clk_en         <= 1'b0;
    end else begin
      // The redirect pulse lasts one cycle even under stall.
      execute_change_pc <= accept && redirect;
      if (flush) begin
        next_clk_en       <= 1'b0;
        execute_exception <= '0;
      end else if (!stall) begin
        if (accept) begin
          next_clk_en         <= 1'b1;
          execute_result      <= result;
          execute_rs2_data    <= rs2_data;
          execute_r_rd        <= decode_r_rd;
          execute_funct3      <= decode_funct3;
          execute_pc          <= decode_pc;
          execute_opcode_type <= decode_opcode_type;
          execute_exception   <= exception_in;
          execute_next_pc     <= target;
        end else begin
          next_clk_en       <= 1'b0;
          execute_exception <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Testbench for the execute stage: directed vectors, expected results queued
// at issue time and checked by an independent output monitor.
module tb_execute;

  localparam int AW = 14, OW = 11, EW = 4;

  // ALU one-hot values
  localparam logic [AW-1:0] ADD = 14'h0001, SUB = 14'h0002, SLT = 14'h0004;
  localparam logic [AW-1:0] SLTU = 14'h0008, XOR_ = 14'h0010, SLL = 14'h0080;
  localparam logic [AW-1:0] SRA = 14'h0200, EQ = 14'h0400, NEQ = 14'h0800;
  localparam logic [AW-1:0] GE = 14'h1000;
  // Opcode one-hot values
  localparam logic [OW-1:0] RTYPE = 11'h001, ITYPE = 11'h002, BRANCH = 11'h010;
  localparam logic [OW-1:0] JAL = 11'h020, JALR = 11'h040, LUI = 11'h080;
  localparam logic [OW-1:0] AUIPC = 11'h100;

  typedef struct packed {
    logic [31:0]   result;
    logic [31:0]   rs2;
    logic [4:0]    rd;
    logic [2:0]    f3;
    logic [31:0]   pc;
    logic [OW-1:0] opc;
    logic [EW-1:0] exc;
    logic          change;
    logic [31:0]   next_pc;
  } exp_t;

  logic clk, rst;
  logic [31:0] decode_pc, rs1_data, rs2_data, decode_imm;
  logic [4:0]  decode_r_rs1, decode_r_rs2, decode_r_rd;
  logic [2:0]  decode_funct3;
  logic [AW-1:0] decode_alu_type;
  logic [OW-1:0] decode_opcode_type;
  logic [EW-1:0] decode_exception;
  logic [31:0] execute_result, execute_rs2_data, execute_pc, execute_next_pc;
  logic [4:0]  execute_r_rd;
  logic [2:0]  execute_funct3;
  logic [OW-1:0] execute_opcode_type;
  logic [EW-1:0] execute_exception;
  logic execute_change_pc, clk_en, next_clk_en, stall, next_stall, flush, next_flush;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  logic last_stall, last_flush;

  execute dut (
    .clk(clk), .rst(rst),
    .decode_pc(decode_pc), .decode_r_rs1(decode_r_rs1), .decode_r_rs2(decode_r_rs2),
    .decode_r_rd(decode_r_rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .decode_imm(decode_imm), .decode_funct3(decode_funct3),
    .decode_alu_type(decode_alu_type), .decode_opcode_type(decode_opcode_type),
    .decode_exception(decode_exception),
    .execute_result(execute_result), .execute_rs2_data(execute_rs2_data),
    .execute_r_rd(execute_r_rd), .execute_funct3(execute_funct3),
    .execute_pc(execute_pc), .execute_opcode_type(execute_opcode_type),
    .execute_exception(execute_exception), .execute_change_pc(execute_change_pc),
    .execute_next_pc(execute_next_pc),
    .clk_en(clk_en), .next_clk_en(next_clk_en),
    .stall(stall), .next_stall(next_stall),
    .flush(flush), .next_flush(next_flush)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    clk_en = 1'b0;
    decode_alu_type = '0;
    decode_opcode_type = '0;
    decode_exception = '0;
  endtask

  // Drive one instruction; queue its expected outcome when it should be accepted.
  task automatic issue(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [AW-1:0] alu, input logic [OW-1:0] opc,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [EW-1:0] exc_in,
                       input bit push, input logic [31:0] e_result, input logic e_change,
                       input logic [31:0] e_next, input logic [EW-1:0] e_exc);
    exp_t e;
    clk_en = 1'b1;
    decode_pc = pc; rs1_data = rs1; rs2_data = rs2; decode_imm = imm;
    decode_alu_type = alu; decode_opcode_type = opc;
    decode_r_rd = rd; decode_r_rs1 = rd + 5'd1; decode_r_rs2 = rd + 5'd2;
    decode_funct3 = f3; decode_exception = exc_in;
    if (push) begin
      e.result = e_result; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.pc = pc;
      e.opc = opc; e.exc = e_exc; e.change = e_change; e.next_pc = e_next;
      exp_q.push_back(e);
    end
  endtask

  // Record the handshake inputs seen at each active edge
  always @(posedge clk) begin
    last_stall = stall;
    last_flush = flush;
  end

  // Monitor: a freshly loaded instruction is compared against the queue head
  always @(negedge clk) begin
    if (!rst && next_clk_en && !last_stall && !last_flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", execute_result, e.result);
        check("rs2_data", execute_rs2_data, e.rs2);
        check("rd", {27'd0, execute_r_rd}, {27'd0, e.rd});
        check("funct3", {29'd0, execute_funct3}, {29'd0, e.f3});
        check("pc", execute_pc, e.pc);
        check("opcode", {21'd0, execute_opcode_type}, {21'd0, e.opc});
        check("exception", {28'd0, execute_exception}, {28'd0, e.exc});
        check("change_pc", {31'd0, execute_change_pc}, {31'd0, e.change});
        if (e.change) check("next_pc", execute_next_pc, e.next_pc);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, execute_result, 32'd0);
    check({tag, "_rs2"}, execute_rs2_data, 32'd0);
    check({tag, "_rd"}, {27'd0, execute_r_rd}, 32'd0);
    check({tag, "_f3"}, {29'd0, execute_funct3}, 32'd0);
    check({tag, "_pc"}, execute_pc, 32'd0);
    check({tag, "_opc"}, {21'd0, execute_opcode_type}, 32'd0);
    check({tag, "_exc"}, {28'd0, execute_exception}, 32'd0);
    check({tag, "_change"}, {31'd0, execute_change_pc}, 32'd0);
    check({tag, "_next_pc"}, execute_next_pc, 32'd0);
    check({tag, "_clk_en"}, {31'd0, next_clk_en}, 32'd0);
    check({tag, "_flush"}, {31'd0, next_flush}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    decode_pc = '0; rs1_data = '0; rs2_data = '0; decode_imm = '0;
    decode_r_rs1 = '0; decode_r_rs2 = '0; decode_r_rd = '0; decode_funct3 = '0;
    idle();
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Arithmetic and logic, back to back
    issue(32'd0, 32'd10, 32'd3, 32'd0, SUB, RTYPE, 5'd5, 3'd0, 4'h0, 1, 32'd7, 0, 32'd0, 4'h0);
    step();
    issue(32'd4, 32'd0, 32'd0, 32'hFFFFFF6A, XOR_, ITYPE, 5'd6, 3'd4, 4'h0, 1, 32'hFFFFFF6A, 0, 32'd0, 4'h0);
    step();
    issue(32'd8, 32'h80000000, 32'd0, 32'd4, SRA, ITYPE, 5'd7, 3'd5, 4'h0, 1, 32'hF8000000, 0, 32'd0, 4'h0);
    step();
    issue(32'd12, 32'hFFFFFFFF, 32'd1, 32'd0, SLT, RTYPE, 5'd8, 3'd2, 4'h0, 1, 32'd1, 0, 32'd0, 4'h0);
    step();
    issue(32'd16, 32'hFFFFFFFF, 32'd1, 32'd0, SLTU, RTYPE, 5'd9, 3'd3, 4'h4, 1, 32'd0, 0, 32'd0, 4'h4);
    step();
    issue(32'd20, 32'hDEADBEEF, 32'd0, 32'h12345000, ADD, LUI, 5'd10, 3'd0, 4'h0, 1, 32'h12345000, 0, 32'd0, 4'h0);
    step();
    issue(32'h100, 32'd7, 32'd0, 32'h1000, ADD, AUIPC, 5'd11, 3'd0, 4'h0, 1, 32'h1100, 0, 32'd0, 4'h0);
    step();
    issue(32'h104, 32'd1, 32'h25, 32'd0, SLL, RTYPE, 5'd12, 3'd1, 4'h0, 1, 32'd32, 0, 32'd0, 4'h0);
    step();
    issue(32'h108, 32'd5, 32'd6, 32'd0, ADD | SUB, RTYPE, 5'd13, 3'd0, 4'h0, 1, 32'd0, 0, 32'd0, 4'h0);
    step();

    // Branch not taken, then taken BGE with redirect and dropped follower
    issue(32'd8, 32'd1, 32'd2, 32'd8, EQ, BRANCH, 5'd0, 3'd0, 4'h0, 1, 32'd0, 0, 32'd0, 4'h0);
    step();
    issue(32'd16, 32'd5, 32'd1, 32'hFFFFFFF0, GE, BRANCH, 5'd0, 3'd5, 4'h0, 1, 32'd1, 1, 32'd0, 4'h0);
    step();
    check("bge_pulse", {31'd0, execute_change_pc}, 32'd1);
    check("bge_next_flush", {31'd0, next_flush}, 32'd1);
    issue(32'd20, 32'd1, 32'd1, 32'd0, ADD, RTYPE, 5'd3, 3'd0, 4'h0, 0, 32'd0, 0, 32'd0, 4'h0);
    step();
    check("dropped_clk_en", {31'd0, next_clk_en}, 32'd0);
    check("pulse_one_cycle", {31'd0, execute_change_pc}, 32'd0);

    // Jumps: aligned JAL, JALR clearing bit 0, misaligned JALR and branch
    issue(32'd20, 32'd0, 32'd0, 32'd16, ADD, JAL, 5'd1, 3'd0, 4'h0, 1, 32'd24, 1, 32'd36, 4'h0);
    step(); idle(); step();
    issue(32'd40, 32'h21, 32'd0, 32'd0, ADD, JALR, 5'd1, 3'd0, 4'h0, 1, 32'd44, 1, 32'h20, 4'h0);
    step(); idle(); step();
    issue(32'd48, 32'h22, 32'd0, 32'd0, ADD, JALR, 5'd1, 3'd0, 4'h0, 1, 32'd52, 0, 32'd0, 4'h1);
    step();
    issue(32'd64, 32'd1, 32'd2, 32'd2, NEQ, BRANCH, 5'd0, 3'd1, 4'h0, 1, 32'd1, 0, 32'd0, 4'h1);
    step();

    // Flush wins over a redirecting instruction
    flush = 1'b1;
    issue(32'd80, 32'd0, 32'd0, 32'd8, ADD, JAL, 5'd1, 3'd0, 4'h0, 0, 32'd0, 0, 32'd0, 4'h0);
    step();
    check("flush_clk_en", {31'd0, next_clk_en}, 32'd0);
    check("flush_change", {31'd0, execute_change_pc}, 32'd0);
    check("flush_exc", {28'd0, execute_exception}, 32'd0);
    check("flush_next_flush", {31'd0, next_flush}, 32'd1);
    flush = 1'b0;

    // Stall holds an accepted ADD for three cycles
    issue(32'd84, 32'd40, 32'd2, 32'd0, ADD, RTYPE, 5'd4, 3'd0, 4'h0, 1, 32'd42, 0, 32'd0, 4'h0);
    step();
    stall = 1'b1;
    issue(32'd88, 32'd1, 32'd1, 32'd0, SUB, RTYPE, 5'd9, 3'd0, 4'h0, 0, 32'd0, 0, 32'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_result", execute_result, 32'd42);
      check("stall_hold_rd", {27'd0, execute_r_rd}, 32'd4);
      check("stall_next_stall", {31'd0, next_stall}, 32'd1);
      check("stall_clk_en", {31'd0, next_clk_en}, 32'd1);
    end
    flush = 1'b1;
    step();
    check("stall_flush_clk_en", {31'd0, next_clk_en}, 32'd0);
    flush = 1'b0; stall = 1'b0; idle();
    step();

    // Redirect pulse clears even while stalled
    issue(32'd100, 32'd0, 32'd0, 32'd4, ADD, JAL, 5'd2, 3'd0, 4'h0, 1, 32'd104, 1, 32'd104, 4'h0);
    step();
    stall = 1'b1; idle();
    step();
    check("stall_pulse_clear", {31'd0, execute_change_pc}, 32'd0);
    check("stall_pulse_clk_en", {31'd0, next_clk_en}, 32'd1);
    stall = 1'b0;
    step();

    // Asynchronous reset during a redirect pulse
    issue(32'd200, 32'd0, 32'd0, 32'd8, ADD, JAL, 5'd3, 3'd0, 4'h0, 1, 32'd204, 1, 32'd208, 4'h0);
    step();
    idle();
    #4;
    check("pre_reset_pulse", {31'd0, execute_change_pc}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    rst = 1'b0;
    step(); step();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the RV32I 5-stage pipeline. It sits directly downstream of `decode` and upstream of the memory stage. It:
- registers the decoded instruction and computes the ALU result, branch decision and jump target;
- redirects `fetch` through `execute_change_pc`/`execute_next_pc`;
- passes its results to the memory stage using the same `clk_en`/`stall`/`flush` handshake as the other stages.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `decode_pc` input 32: PC of the decoded instruction.
- `decode_r_rs1`, `decode_r_rs2`, `decode_r_rd` input 5 each: registered register addresses.
- `rs1_data`, `rs2_data` input 32 each: operand values, already forwarded by the hazard unit.
- `decode_imm` input 32: sign-extended immediate.
- `decode_funct3` input 3: funct3 field.
- `decode_alu_type` input `ALU_WIDTH`: one-hot ALU operation (ADD…GEU).
- `decode_opcode_type` input `OPCODE_WIDTH`: one-hot opcode class.
- `decode_exception` input `EXCEPTION_WIDTH`: exceptions raised upstream.
- `execute_result` output 32: ALU result, or link address for JAL/JALR.
- `execute_rs2_data` output 32: store data.
- `execute_r_rd` output 5, `execute_funct3` output 3, `execute_pc` output 32, `execute_opcode_type` output `OPCODE_WIDTH`, `execute_exception` output `EXCEPTION_WIDTH`: registered copies for the downstream stages.
- `execute_change_pc` output 1: one-cycle redirect pulse to `fetch`.
- `execute_next_pc` output 32: redirect target.
- `clk_en` input 1: `decode` holds a valid instruction.
- `next_clk_en` output 1: `execute` holds a valid instruction.
- `stall` input 1: stall request from the memory stage.
- `next_stall` output 1: stall request to `decode`.
- `flush` input 1: flush request from a later stage.
- `next_flush` output 1: flush request to `decode`/`fetch`.

## Operation
- Operand A: `decode_pc` for AUIPC, JAL and JALR-link; 0 for LUI; `rs1_data` otherwise.
- Operand B: `rs2_data` for RTYPE and BRANCH; `decode_imm` otherwise.
- ALU operations, selected by the one-hot `decode_alu_type`:
  - ADD/SUB: wrap mod 2^32.
  - SLT: signed compare; SLTU: unsigned compare; both give 1/0.
  - XOR, OR, AND: bitwise.
  - SLL/SRL/SRA: shift amount is B[4:0].
  - EQ, NEQ, GE (signed), GEU: give 1/0.
  - BLT uses SLT; BLTU uses SLTU.
  - Any other `alu_type` value (none set, or more than one set): result 0.
- Branches: the branch is taken when ALU bit0 is 1. The target is `decode_pc + decode_imm`.
- JAL: target `decode_pc + decode_imm`; result `decode_pc + 4`.
- JALR: target `(rs1_data + decode_imm) & ~1`; result `decode_pc + 4`.
- Redirect: a taken branch, JAL or JALR with a target whose bits [1:0] are not 00 must not redirect. Instead it sets the instruction-address-misaligned bit in `execute_exception`.
- Accepting an instruction: the stage accepts one on a rising edge when all of the following hold:
  - `clk_en` is 1;
  - `stall` is 0;
  - `flush` is 0;
  - `execute_change_pc` is 0 (the younger instruction following a redirect is dropped).
- On accept: `next_clk_en` is 1 and all `execute_*` registers load.
- On a flush or a dropped instruction (stall 0): `next_clk_en` is 0, and `execute_change_pc` and `execute_exception` are 0.
- While `stall` is 1, all registers including `next_clk_en` hold their values.
- `next_stall = stall`, combinational.
- `next_flush = flush | execute_change_pc`, combinational.
- `execute_change_pc` is a registered one-cycle pulse. It is set on accept of a redirecting instruction and cleared on the following edge, even if `stall` is asserted.

## Timing
- Reset: every output is 0, including `next_clk_en`, `execute_change_pc`, `execute_next_pc` and `execute_result`.
- Latency: one cycle. Inputs sampled at edge N appear on the `execute_*` outputs after edge N.
- `execute_change_pc` is high for exactly the cycle after edge N. `fetch` loads `execute_next_pc` at edge N+1.
- During that cycle `next_flush` is 1, so both the instruction in `decode` and the one in `fetch` are discarded.
- Simultaneous `flush` and a redirecting input: `flush` wins; no redirect and no exception.
- Simultaneous `stall` and `flush`: `flush` wins; `next_clk_en` becomes 0.
- Reset asserted mid-operation: all registers clear immediately (asynchronously); the pending redirect is lost.
- Back-to-back valid instructions: one accepted per cycle, with no bubble.

## Test plan
- RTYPE SUB at pc 0, rs1=10, rs2=3 → after one edge: `execute_result`=7, `next_clk_en`=1, `execute_change_pc`=0.
- XORI with imm=-150 and rs1=0 → `execute_result`=0xFFFFFF6A. SRAI with rs1=0x80000000 and imm=4 → `execute_result`=0xF8000000.
- BGE at pc 16, rs1=5, rs2=1, imm=-16 → one-cycle `execute_change_pc` pulse with `execute_next_pc`=0. During the pulse `next_flush`=1, and the following valid input is not accepted.
- JAL at pc 20, imm 16 → `execute_result`=24, `execute_next_pc`=36. JALR with rs1=0x21 and imm=0 → target 0x20. JALR with rs1=0x22 → no redirect; misaligned exception bit set.
- `stall` held 3 cycles after accepting ADD with result 42 → `execute_result`=42 is held and `next_stall`=1 throughout. `stall` and `flush` together → `next_clk_en`=0.
- Assert `rst` asynchronously during a redirect pulse → all outputs 0 immediately, before the next clock edge.
